// File: rtl/bus_rr_arbiter.sv
// Two-master round-robin arbiter that sequences one ce/rd/wr transfer
// per grant on the shared memory bus and returns a one-cycle ack.
module bus_rr_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ce,
    output logic              rd,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_wr,
    input  logic [DATA_W-1:0] data_rd,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic              gnt, gnt_d;
    logic              last_grant, last_grant_d;
    logic              is_rd, is_rd_d;
    logic              ce_d, rd_d, wr_d, busy_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_wr_d;
    logic              m0_ack_d, m1_ack_d;
    logic [DATA_W-1:0] m0_rdata_d, m1_rdata_d;

    // Tie goes to the master that did not win the previous tie
    logic              tie, sel, sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign tie       = m0_req && m1_req;
    assign sel       = tie ? ~last_grant : m1_req;
    assign sel_we    = sel ? m1_we : m0_we;
    assign sel_addr  = sel ? m1_addr : m0_addr;
    assign sel_wdata = sel ? m1_wdata : m0_wdata;

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        gnt_d        = gnt;
        last_grant_d = last_grant;
        is_rd_d      = is_rd;
        ce_d         = ce;
        rd_d         = rd;
        wr_d         = wr;
        busy_d       = busy;
        addr_d       = addr;
        data_wr_d    = data_wr;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_rdata_d   = m0_rdata;
        m1_rdata_d   = m1_rdata;
        unique case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    if (tie) last_grant_d = sel;
                    gnt_d     = sel;
                    is_rd_d   = ~sel_we;
                    ce_d      = 1'b1;
                    wr_d      = sel_we;
                    rd_d      = ~sel_we;
                    addr_d    = sel_addr;
                    data_wr_d = sel_we ? sel_wdata : '0;
                    cnt_d     = CNT_INIT;
                    busy_d    = 1'b1;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else begin
                    if (is_rd && gnt)  m1_rdata_d = data_rd;
                    if (is_rd && !gnt) m0_rdata_d = data_rd;
                    ce_d      = 1'b0;
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    addr_d    = '0;
                    data_wr_d = '0;
                    m0_ack_d  = ~gnt;
                    m1_ack_d  = gnt;
                    state_d   = ACK;
                end
            end
            ACK: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            is_rd      <= 1'b0;
            ce         <= 1'b0;
            rd         <= 1'b0;
            wr         <= 1'b0;
            busy       <= 1'b0;
            addr       <= '0;
            data_wr    <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            gnt        <= gnt_d;
            last_grant <= last_grant_d;
            is_rd      <= is_rd_d;
            ce         <= ce_d;
            rd         <= rd_d;
            wr         <= wr_d;
            busy       <= busy_d;
            addr       <= addr_d;
            data_wr    <= data_wr_d;
            m0_ack     <= m0_ack_d;
            m1_ack     <= m1_ack_d;
            m0_rdata   <= m0_rdata_d;
            m1_rdata   <= m1_rdata_d;
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Randomized scoreboard bench for bus_rr_arbiter with a memory slave model.
module tb_bus_rr_arbiter;

    localparam int AC = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m0_req = 1'b0, m0_we = 1'b0;
    logic [7:0] m0_addr = '0, m0_wdata = '0;
    logic       m0_ack;
    logic [7:0] m0_rdata;
    logic       m1_req = 1'b0, m1_we = 1'b0;
    logic [7:0] m1_addr = '0, m1_wdata = '0;
    logic       m1_ack;
    logic [7:0] m1_rdata;
    logic       ce, rd, wr, busy;
    logic [7:0] addr, data_wr, data_rd;

    always #5 clk = ~clk;

    bus_rr_arbiter #(.ADDR_W(8), .DATA_W(8), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ce(ce), .rd(rd), .wr(wr), .addr(addr), .data_wr(data_wr),
        .data_rd(data_rd), .busy(busy)
    );

    // Slave memory on the bus
    logic [7:0] mem [256];
    assign data_rd = mem[addr];
    always @(posedge clk) if (rst_n && ce && wr) mem[addr] <= data_wr;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         m;
        bit         we;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rdata;
        int         start;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: memory contents in grant order, and next tie winner
    logic [7:0] ref_mem [256];
    int         next_tie = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(int m, bit we, logic [7:0] a, logic [7:0] d, int start);
        exp_t e;
        e.m = m; e.we = we; e.a = a; e.d = d; e.start = start;
        e.rdata = we ? 8'h00 : ref_mem[a];
        if (we) ref_mem[a] = d;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_round(input bit r0, input bit r1, input bit we0, input bit we1,
                             input logic [7:0] a0, input logic [7:0] a1,
                             input logic [7:0] d0, input logic [7:0] d1);
        int c, n, first;
        c = cyc;
        m0_we = we0; m0_addr = a0; m0_wdata = d0;
        m1_we = we1; m1_addr = a1; m1_wdata = d1;
        m0_req = r0; m1_req = r1;
        if (r0 && r1) begin
            first = next_tie;
            next_tie = 1 - next_tie;
            if (first == 0) begin
                q.push_back(mk(0, we0, a0, d0, c + 1));
                q.push_back(mk(1, we1, a1, d1, c + 1 + AC + 2));
            end else begin
                q.push_back(mk(1, we1, a1, d1, c + 1));
                q.push_back(mk(0, we0, a0, d0, c + 1 + AC + 2));
            end
        end else if (r0) begin
            q.push_back(mk(0, we0, a0, d0, c + 1));
        end else begin
            q.push_back(mk(1, we1, a1, d1, c + 1));
        end
        n = 0;
        while ((m0_req || m1_req) && n < 100) begin
            tick();
            n++;
            if (m0_ack) m0_req = 1'b0;
            if (m1_ack) m1_req = 1'b0;
        end
        if (m0_req || m1_req) begin
            chk("ack_timeout", 32'(m0_req || m1_req), 32'd0);
            m0_req = 1'b0; m1_req = 1'b0;
        end
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("idle_after_round", 32'(busy), 32'd0);
        repeat ($urandom_range(0, 2)) tick();
    endtask

    // Monitor: pops one expected transfer per ack
    bit         in_x = 0, prev_ce = 0, rd_c, wr_c;
    int         ce_len = 0, st = 0;
    logic [7:0] a_c, dw_c;
    logic [7:0] exp_rd [2] = '{8'h00, 8'h00};

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            in_x = 0; ce_len = 0; prev_ce = 0;
            exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        end else begin
            chk("ack_excl", 32'(m0_ack && m1_ack), 32'd0);
            chk("rd_wr_excl", 32'(rd && wr), 32'd0);
            if (ce) begin
                if (!in_x) begin
                    in_x = 1; ce_len = 0; st = cyc;
                    a_c = addr; dw_c = data_wr; rd_c = rd; wr_c = wr;
                end
                ce_len++;
                chk("bus_hold", {addr, data_wr, 6'd0, rd, wr}, {a_c, dw_c, 6'd0, rd_c, wr_c});
                chk("busy_in_access", 32'(busy), 32'd1);
            end
            if (m0_ack || m1_ack) begin
                if (q.size() == 0) begin
                    chk("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("ack_master", 32'(m1_ack), 32'(e.m));
                    chk("ack_after_ce", {29'd0, prev_ce, ce, in_x}, 32'd5);
                    chk("ce_len", 32'(ce_len), 32'(AC));
                    chk("start_cycle", 32'(st), 32'(e.start));
                    chk("bus_addr", 32'(a_c), 32'(e.a));
                    chk("bus_strobe", {30'd0, wr_c, rd_c}, {30'd0, e.we, ~e.we});
                    chk("bus_wdata", 32'(dw_c), 32'(e.we ? e.d : 8'h00));
                    if (!e.we) exp_rd[e.m] = e.rdata;
                    chk("m0_rdata", 32'(m0_rdata), 32'(exp_rd[0]));
                    chk("m1_rdata", 32'(m1_rdata), 32'(exp_rd[1]));
                    chk("bus_idle_ack", {15'd0, ce, rd, wr, addr, data_wr}, 32'd0);
                end
                in_x = 0;
            end
            prev_ce = ce;
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        // Reset with a pending request: nothing may move
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h55; m0_wdata = 8'h11;
        repeat (3) tick();
        chk("rst_ctrl", {26'd0, ce, rd, wr, busy, m0_ack, m1_ack}, 32'd0);
        chk("rst_bus", {16'd0, addr, data_wr}, 32'd0);
        chk("rst_rdata", {16'd0, m0_rdata, m1_rdata}, 32'd0);
        m0_req = 1'b0;
        rst_n = 1'b1;
        tick();

        run_round(1, 0, 1, 0, 8'h02, 8'h00, 8'hAC, 8'h00);
        run_round(1, 0, 0, 0, 8'h02, 8'h00, 8'h00, 8'h00);
        run_round(1, 1, 1, 0, 8'h12, 8'h12, 8'hBD, 8'h00);
        run_round(1, 1, 0, 1, 8'h12, 8'h13, 8'h00, 8'h77);
        run_round(1, 1, 0, 0, 8'h13, 8'h02, 8'h00, 8'h00);
        run_round(0, 1, 0, 1, 8'h00, 8'h22, 8'h00, 8'h5A);

        for (int i = 0; i < 60; i++) begin
            int k;
            k = $urandom_range(0, 2);
            run_round(k != 1, k != 0, 1'($urandom), 1'($urandom),
                      8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                      8'($urandom), 8'($urandom));
        end

        // Make m1 the next tie winner so a reset visibly restores m0 priority
        if (next_tie == 0)
            run_round(1, 1, 0, 0, 8'h01, 8'h02, 8'h00, 8'h00);
        m1_we = 1'b1; m1_addr = 8'h30; m1_wdata = 8'h77; m1_req = 1'b1;
        n = 0;
        while (!ce && n < 10) begin
            tick();
            n++;
        end
        chk("ce_before_reset", 32'(ce), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bus", {15'd0, ce, rd, wr, addr, data_wr}, 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        m1_req = 1'b0;
        tick();
        chk("no_ack_after_abort", {30'd0, m0_ack, m1_ack}, 32'd0);
        rst_n = 1'b1;
        next_tie = 0;
        tick();
        run_round(1, 1, 0, 0, 8'h30, 8'h02, 8'h00, 8'h00);

        for (int i = 0; i < 20; i++) begin
            int k;
            k = $urandom_range(0, 2);
            run_round(k != 1, k != 0, 1'($urandom), 1'($urandom),
                      8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                      8'($urandom), 8'($urandom));
        end

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
